sha256_msg_sched: RTL and testbench

// Producer side of the hash core's per-round word interface. Accepts one padded 512-bit

---
 rtl/sha256_msg_sched.sv | 143 ++++++++++++++
 tb/tb_sha256_msg_sched.sv | 341 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sha256_msg_sched.sv
// sha256_msg_sched
// Producer side of the hash core's per-round word interface. A padded
// 512-bit block is accepted while idle. The scheduler then emits a one-cycle
// load pulse and then one (Wt, Kt, t) triple per cycle for rounds
// 0..ROUNDS-1. The core cannot stall, so the cadence is fixed. A one-cycle
// done pulse follows the last round.
//
// Handshake: block_ready_o is high only in IDLE. A block transfers on the
// rising edge where block_valid_i & block_ready_o are both high. block_i is
// sampled only on that edge and may change afterwards. There is no
// back-pressure on the output side: wt_valid_o marks every round cycle.
//
// Ports
//   clk, rst        clock (rising edge), asynchronous active-high reset
//   block_i         padded block, big-endian (M0 = block_i[511:480])
//   block_valid_i   block_i is valid
//   block_ready_o   idle; a block is accepted when valid & ready
//   load_o          1-cycle pulse to the core's load pin
//   Wt_o, Kt_o      schedule word W[t] and round constant K[t]
//   round_o         round index t
//   wt_valid_o      Wt_o/Kt_o/round_o are valid (forced to 0 otherwise)
//   busy_o          block in flight (LOAD or RUN)
//   done_o          1-cycle pulse in the cycle after the last round
//   state_o         current FSM state (0 IDLE, 1 LOAD, 2 RUN)
// ROUNDS: legal range 16..64. Values below 64 are for debug/formal use only.
module sha256_msg_sched #(
  parameter int ROUNDS = 64
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [511:0] block_i,
  input  logic         block_valid_i,
  output logic         block_ready_o,
  output logic         load_o,
  output logic [31:0]  Wt_o,
  output logic [31:0]  Kt_o,
  output logic [5:0]   round_o,
  output logic         wt_valid_o,
  output logic         busy_o,
  output logic         done_o,
  output logic [1:0]   state_o
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_RUN  = 2'd2
  } state_t;

  localparam logic [31:0] K_TABLE [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  state_t      state_q, state_d;
  logic [31:0] w_q [16];
  logic [5:0]  t_q;
  logic        done_q;
  logic        accept;
  logic        last_round;
  logic [31:0] w_next;

  function automatic logic [31:0] sig0(input logic [31:0] x);
    return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ {3'b000, x[31:3]};
  endfunction

  function automatic logic [31:0] sig1(input logic [31:0] x);
    return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ {10'b0, x[31:10]};
  endfunction

  assign accept     = (state_q == S_IDLE) && block_valid_i;
  assign last_round = (t_q == 6'(ROUNDS - 1));
  // The window holds W[t..t+15], so W[t+16] is built from its fixed taps.
  assign w_next     = sig1(w_q[14]) + w_q[9] + sig0(w_q[1]) + w_q[0];

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (accept) state_d = S_LOAD;
      S_LOAD:  state_d = S_RUN;
      S_RUN:   if (last_round) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Window, round counter and done flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 16; i++) w_q[i] <= '0;
      t_q    <= '0;
      done_q <= 1'b0;
    end else begin
      // done lands in the first IDLE cycle, together with ready.
      done_q <= (state_q == S_RUN) && last_round;
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            for (int i = 0; i < 16; i++) w_q[i] <= block_i[511 - 32*i -: 32];
          end
        end
        S_LOAD: t_q <= '0;
        S_RUN: begin
          for (int i = 0; i < 15; i++) w_q[i] <= w_q[i+1];
          w_q[15] <= w_next;
          t_q     <= t_q + 6'd1;
        end
        default: ;
      endcase
    end
  end

  // Outputs are decoded from registered state, so reset clears them at once.
  always_comb begin
    block_ready_o = (state_q == S_IDLE);
    busy_o        = (state_q != S_IDLE);
    load_o        = (state_q == S_LOAD);
    wt_valid_o    = (state_q == S_RUN);
    Wt_o          = '0;
    Kt_o          = '0;
    round_o       = '0;
    if (state_q == S_RUN) begin
      Wt_o    = w_q[0];
      Kt_o    = K_TABLE[t_q];
      round_o = t_q;
    end
    done_o  = done_q;
    state_o = state_q;
  end

endmodule

// File: tb/tb_sha256_msg_sched.sv
// Bench for sha256_msg_sched. The reference schedule uses the textbook
// recurrence over a 64-entry array, W[t] = s1(W[t-2]) + W[t-7] + s0(W[t-15]) + W[t-16].
// Per-cycle traces are taken at the falling edge, starting with the
// acceptance cycle A at index 0.
module tb_sha256_msg_sched;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [511:0] block_i = '0;
  logic         block_valid_i = 1'b0;
  logic         block_ready_o, load_o, wt_valid_o, busy_o, done_o;
  logic [31:0]  Wt_o, Kt_o;
  logic [5:0]   round_o;
  logic [1:0]   state_o;

  int total = 0;
  int bad   = 0;

  logic [31:0] exp_q[$];
  logic [31:0] ref_w [64];

  localparam logic [31:0] K_REF [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  localparam logic [511:0] ABC_BLOCK = {32'h61626380, 448'b0, 32'h00000018};

  localparam int TR = 140;
  logic        tr_ready [TR];
  logic        tr_load  [TR];
  logic        tr_valid [TR];
  logic        tr_busy  [TR];
  logic        tr_done  [TR];
  logic [31:0] tr_w     [TR];
  logic [31:0] tr_k     [TR];
  logic [5:0]  tr_r     [TR];

  sha256_msg_sched #(.ROUNDS(64)) dut (
    .clk           (clk),
    .rst           (rst),
    .block_i       (block_i),
    .block_valid_i (block_valid_i),
    .block_ready_o (block_ready_o),
    .load_o        (load_o),
    .Wt_o          (Wt_o),
    .Kt_o          (Kt_o),
    .round_o       (round_o),
    .wt_valid_o    (wt_valid_o),
    .busy_o        (busy_o),
    .done_o        (done_o),
    .state_o       (state_o)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] ref_s0(input logic [31:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] ref_s1(input logic [31:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  function automatic void ref_schedule(input logic [511:0] blk);
    for (int t = 0; t < 64; t++) begin
      if (t < 16) ref_w[t] = blk[511 - 32*t -: 32];
      else        ref_w[t] = ref_s1(ref_w[t-2]) + ref_w[t-7] + ref_s0(ref_w[t-15]) + ref_w[t-16];
    end
  endfunction

  function automatic void push_expected(input logic [511:0] blk);
    ref_schedule(blk);
    for (int t = 0; t < 64; t++) exp_q.push_back(ref_w[t]);
  endfunction

  function automatic logic [511:0] rand_block();
    logic [511:0] b;
    for (int i = 0; i < 16; i++) b[32*i +: 32] = $urandom;
    return b;
  endfunction

  // ---------------- driver ----------------
  // Presents blk in cycle A (index 0) and records ncyc cycles of outputs.
  // With two=1, valid stays high and blk2 is offered from cycle A+1 until
  // the cycle after its expected acceptance at A+66.
  task automatic capture(input logic [511:0] blk, input logic [511:0] blk2,
                         input bit two, input int ncyc);
    @(negedge clk);
    block_i       = blk;
    block_valid_i = 1'b1;
    for (int k = 0; k < ncyc; k++) begin
      tr_ready[k] = block_ready_o;
      tr_load[k]  = load_o;
      tr_valid[k] = wt_valid_o;
      tr_busy[k]  = busy_o;
      tr_done[k]  = done_o;
      tr_w[k]     = Wt_o;
      tr_k[k]     = Kt_o;
      tr_r[k]     = round_o;
      if (k == 1) begin
        if (two) block_i = blk2;
        else begin
          block_valid_i = 1'b0;
          block_i       = rand_block();
        end
      end
      if (two && k == 67) begin
        block_valid_i = 1'b0;
        block_i       = rand_block();
      end
      if (k < ncyc - 1) @(negedge clk);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst           = 1'b1;
    block_valid_i = 1'b1;
    block_i       = rand_block();
    repeat (3) @(negedge clk);
    total++;
    if (block_ready_o !== 1'b1 || load_o !== 1'b0 || wt_valid_o !== 1'b0 || busy_o !== 1'b0 ||
        done_o !== 1'b0 || Wt_o !== 32'h0 || Kt_o !== 32'h0 || round_o !== 6'h0 || state_o !== 2'd0) begin
      bad++;
      $display("FAIL reset_state: ready=%b load=%b valid=%b busy=%b done=%b w=%h k=%h r=%0d st=%0d, required ready=1 rest 0",
               block_ready_o, load_o, wt_valid_o, busy_o, done_o, Wt_o, Kt_o, round_o, state_o);
    end
    rst           = 1'b0;
    block_valid_i = 1'b0;
    @(negedge clk);
    total++;
    if (block_ready_o !== 1'b1 || busy_o !== 1'b0 || load_o !== 1'b0) begin
      bad++;
      $display("FAIL reset_release_idle: ready=%b busy=%b load=%b, required 1 0 0", block_ready_o, busy_o, load_o);
    end
  endtask

  task automatic test_abc();
    logic [31:0] exp;
    capture(ABC_BLOCK, '0, 1'b0, 68);
    push_expected(ABC_BLOCK);
    total++;
    if (tr_w[2] !== 32'h61626380 || tr_w[17] !== 32'h00000018 || tr_w[18] !== 32'h61626380 ||
        tr_w[19] !== 32'h000F0000 || tr_w[20] !== 32'h7DA86405 || tr_w[21] !== 32'h600003C6 ||
        tr_w[65] !== 32'h12B1EDEB) begin
      bad++;
      $display("FAIL abc_known_words: W0=%h W15=%h W16=%h W17=%h W18=%h W19=%h W63=%h, required 61626380 00000018 61626380 000f0000 7da86405 600003c6 12b1edeb",
               tr_w[2], tr_w[17], tr_w[18], tr_w[19], tr_w[20], tr_w[21], tr_w[65]);
    end
    total++;
    if (tr_k[2] !== 32'h428A2F98 || tr_k[65] !== 32'hC67178F2) begin
      bad++;
      $display("FAIL abc_k_ends: K0=%h K63=%h, required 428a2f98 c67178f2", tr_k[2], tr_k[65]);
    end
    for (int r = 0; r < 64; r++) begin
      exp = exp_q.pop_front();
      total++;
      if (tr_valid[2+r] !== 1'b1 || tr_w[2+r] !== exp || tr_k[2+r] !== K_REF[r] || tr_r[2+r] !== 6'(r)) begin
        bad++;
        $display("FAIL abc_round%0d: valid=%b w=%h k=%h t=%0d, required 1 %h %h %0d",
                 r, tr_valid[2+r], tr_w[2+r], tr_k[2+r], tr_r[2+r], exp, K_REF[r], r);
      end
    end
  endtask

  task automatic test_timing();
    bit e_ready, e_load, e_valid, e_done, e_busy;
    capture(rand_block(), '0, 1'b0, 68);
    for (int k = 0; k < 68; k++) begin
      e_ready = (k == 0) || (k >= 66);
      e_load  = (k == 1);
      e_valid = (k >= 2) && (k <= 65);
      e_done  = (k == 66);
      e_busy  = (k >= 1) && (k <= 65);
      total++;
      if (tr_ready[k] !== e_ready || tr_load[k] !== e_load || tr_valid[k] !== e_valid ||
          tr_done[k] !== e_done || tr_busy[k] !== e_busy) begin
        bad++;
        $display("FAIL timing_A+%0d: ready=%b load=%b valid=%b done=%b busy=%b, required %b %b %b %b %b",
                 k, tr_ready[k], tr_load[k], tr_valid[k], tr_done[k], tr_busy[k],
                 e_ready, e_load, e_valid, e_done, e_busy);
      end
      if (!e_valid) begin
        total++;
        if (tr_w[k] !== 32'h0 || tr_k[k] !== 32'h0 || tr_r[k] !== 6'h0) begin
          bad++;
          $display("FAIL idle_zero_A+%0d: w=%h k=%h t=%0d, required 0 0 0", k, tr_w[k], tr_k[k], tr_r[k]);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [511:0] b1, b2;
    logic [31:0]  exp;
    b1 = rand_block();
    b2 = rand_block();
    capture(b1, b2, 1'b1, 134);
    push_expected(b1);
    push_expected(b2);
    for (int k = 1; k <= 65; k++) begin
      total++;
      if (tr_ready[k] !== 1'b0 || tr_busy[k] !== 1'b1) begin
        bad++;
        $display("FAIL b2b_busy_A+%0d: ready=%b busy=%b, required 0 1", k, tr_ready[k], tr_busy[k]);
      end
    end
    total++;
    if (tr_ready[66] !== 1'b1 || tr_done[66] !== 1'b1 || tr_load[67] !== 1'b1 || tr_ready[67] !== 1'b0) begin
      bad++;
      $display("FAIL b2b_second_accept: ready@66=%b done@66=%b load@67=%b ready@67=%b, required 1 1 1 0",
               tr_ready[66], tr_done[66], tr_load[67], tr_ready[67]);
    end
    for (int r = 0; r < 128; r++) begin
      exp = exp_q.pop_front();
      total++;
      if (tr_w[(r < 64) ? 2 + r : 4 + r] !== exp || tr_valid[(r < 64) ? 2 + r : 4 + r] !== 1'b1) begin
        bad++;
        $display("FAIL b2b_word%0d: w=%h valid=%b, required %h 1",
                 r, tr_w[(r < 64) ? 2 + r : 4 + r], tr_valid[(r < 64) ? 2 + r : 4 + r], exp);
      end
    end
    total++;
    if (tr_done[132] !== 1'b1 || tr_ready[133] !== 1'b1 || tr_done[133] !== 1'b0) begin
      bad++;
      $display("FAIL b2b_second_done: done@132=%b ready@133=%b done@133=%b, required 1 1 0",
               tr_done[132], tr_ready[133], tr_done[133]);
    end
  endtask

  task automatic test_reset_mid_block();
    int done_seen;
    int ready_drop;
    capture(ABC_BLOCK, '0, 1'b0, 33);
    total++;
    if (tr_r[32] !== 6'd30 || tr_valid[32] !== 1'b1) begin
      bad++;
      $display("FAIL midrst_at_round30: t=%0d valid=%b, required 30 1", tr_r[32], tr_valid[32]);
    end
    rst = 1'b1;
    #1;
    total++;
    if (block_ready_o !== 1'b1 || busy_o !== 1'b0 || wt_valid_o !== 1'b0 || load_o !== 1'b0 ||
        done_o !== 1'b0 || Wt_o !== 32'h0 || Kt_o !== 32'h0 || round_o !== 6'h0) begin
      bad++;
      $display("FAIL midrst_async_clear: ready=%b busy=%b valid=%b load=%b done=%b w=%h k=%h t=%0d, required ready=1 rest 0",
               block_ready_o, busy_o, wt_valid_o, load_o, done_o, Wt_o, Kt_o, round_o);
    end
    block_valid_i = 1'b1;
    block_i       = rand_block();
    repeat (3) @(negedge clk);
    rst           = 1'b0;
    block_valid_i = 1'b0;
    done_seen  = 0;
    ready_drop = 0;
    for (int c = 0; c < 70; c++) begin
      @(negedge clk);
      if (done_o !== 1'b0) done_seen++;
      if (block_ready_o !== 1'b1) ready_drop++;
    end
    total++;
    if (done_seen != 0 || ready_drop != 0) begin
      bad++;
      $display("FAIL midrst_no_done: done cycles=%0d not-ready cycles=%0d, required 0 0", done_seen, ready_drop);
    end
    capture(ABC_BLOCK, '0, 1'b0, 68);
    total++;
    if (tr_w[19] !== 32'h000F0000 || tr_done[66] !== 1'b1) begin
      bad++;
      $display("FAIL midrst_restart: W17=%h done@66=%b, required 000f0000 1", tr_w[19], tr_done[66]);
    end
  endtask

  task automatic test_all_ones();
    logic [31:0] exp;
    capture({512{1'b1}}, '0, 1'b0, 68);
    push_expected({512{1'b1}});
    for (int r = 0; r < 64; r++) begin
      exp = exp_q.pop_front();
      if (r >= 16) begin
        total++;
        if (tr_w[2+r] !== exp) begin
          bad++;
          $display("FAIL ones_W%0d: w=%h, required %h", r, tr_w[2+r], exp);
        end
      end
    end
  endtask

  task automatic test_random();
    logic [511:0] b;
    logic [31:0]  exp;
    for (int n = 0; n < 4; n++) begin
      b = rand_block();
      capture(b, '0, 1'b0, 68);
      push_expected(b);
      for (int r = 0; r < 64; r++) begin
        exp = exp_q.pop_front();
        total++;
        if (tr_w[2+r] !== exp || tr_k[2+r] !== K_REF[r] || tr_r[2+r] !== 6'(r)) begin
          bad++;
          $display("FAIL rand%0d_round%0d: w=%h k=%h t=%0d, required %h %h %0d",
                   n, r, tr_w[2+r], tr_k[2+r], tr_r[2+r], exp, K_REF[r], r);
        end
      end
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_abc();
    test_timing();
    test_back_to_back();
    test_reset_mid_block();
    test_all_ones();
    test_random();
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain: left=%0d, required 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
